attn_softmax_sched: RTL and testbench
=====================================

// Module: attn_softmax_sched
// PURPOSE
//  Scheduler between the B2R converter, a bank of NUM_ROWS row-softmax lanes and NUM_OUT R2B converters in a self-attention head.
//  Dispatches input tiles round-robin across lanes with ready/valid backpressure and tracks per-lane occupancy.
//  Issues per-lane done-triggered local resets and maps lane outputs onto R2B channels with a diagonal skew.
//  Runs a slice-level FSM so consecutive Qn*KnT slices stream back-to-back.
// PARAMETERS
//  NUM_ROWS      4  softmax lanes (= NUM_CORES*BLOCK_SIZE), >=2
//  TILES_PER_ROW 2  input tiles accepted by a lane before it is full, >=1
//  NUM_OUT       2  R2B output channels, 1..NUM_ROWS
//  IDX_W         $clog2(NUM_ROWS+NUM_OUT)  row-index / head-pointer width (localparam)
// PORTS
//  clk             in   1               clock
//  rst_n           in   1               synchronous active-low reset
//  in_valid        in   1               B2R tile valid
//  in_last         in   1               last tile of current slice
//  in_ready        out  1               tile accepted when in_valid&&in_ready
//  slice_done_b2r  in   1               B2R finished a slice
//  b2r_rst_n       out  1               local B2R reset, active-low
//  lane_en         out  1               softmax bank enable
//  lane_valid      out  NUM_ROWS        one-hot tile strobe to lanes
//  lane_done       in   NUM_ROWS        lane finished its row
//  lane_out_valid  in   NUM_ROWS        lane result valid
//  lane_rst_n      out  NUM_ROWS        per-lane local reset, active-low
//  r2b_row_idx     out  NUM_OUT*IDX_W   lane selected per channel, packed, ch0 LSBs
//  r2b_valid       out  NUM_OUT         per-channel R2B input strobe
//  r2b_slice_last  in   NUM_OUT         R2B channel consumed its last row
//  r2b_rst_n       out  NUM_OUT         per-channel local R2B reset
//  busy            out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, wr_ptr=0, head=0, all counts/busy=0;
//   outputs in_ready=0, lane_en=0, lane_valid=0, r2b_valid=0, r2b_row_idx=0, busy=0;
//   b2r_rst_n, lane_rst_n, r2b_rst_n = 0 (all held in reset). Any mid-operation reset aborts the slice.
//  FSM IDLE->RUN on in_valid; lane_en rises same edge, sticky until reset.
//   RUN->DRAIN on accepted beat with in_last.
//   DRAIN->FLUSH when all lane_busy=0 and every channel has seen r2b_slice_last.
//   FLUSH (1 cycle): b2r_rst_n=0, head<=0, wr_ptr<=0, then IDLE.
//  Dispatch: in_ready = (state==RUN) && !full[wr_ptr], combinational.
//   On accept: lane_valid<=onehot(wr_ptr) next cycle (1-cycle latency, otherwise 0); cnt[wr_ptr]++;
//   full when cnt==TILES_PER_ROW; wr_ptr wraps NUM_ROWS-1 -> 0 (never equals NUM_ROWS).
//   Stall on full lane: in_ready=0, no skip to other lanes (row order preserved).
//  Lane reset: lane_done[r] sampled high -> lane_rst_n[r]=0 for exactly the next cycle, cnt[r]=0, full[r]=0.
//   lane_done and an accept to the same lane in one cycle: done wins, the beat is not accepted (in_ready forced 0).
//  b2r_rst_n = ~slice_done_b2r registered, and 0 during FLUSH.
//  Output mapping:
//   head increments on any(lane_out_valid), saturating at NUM_ROWS+NUM_OUT-2.
//   channel m: row = head-m; in range iff head>=m && head-m<NUM_ROWS.
//   In range: r2b_row_idx[m]<=row, r2b_valid[m]<=lane_out_valid[row]. Else idx<=0, valid<=0.
//   r2b_rst_n[m] = ~r2b_slice_last[m] registered. Channel slice_last flags are sticky until FLUSH.
//  Simultaneous in_last accept and lane_done: both take effect in that cycle.
// TESTING
//  1 Reset then NUM_ROWS=4, TILES_PER_ROW=2, 8 back-to-back tiles, last on 8th -> lane_valid 1,2,4,8,1,2,4,8 one cycle after each accept; wr_ptr wraps to 0; in_ready stays high; state becomes DRAIN.
//  2 All lanes full, in_valid=1 -> in_ready=0; lane_done[0] pulse -> lane_rst_n[0]=0 one cycle, then in_ready=1 for lane 0 only.
//  3 lane_done[2] and an accept to lane 2 in the same cycle -> beat refused, cnt[2]=0.
//  4 lane_out_valid asserted for rows 0..3 sequentially, NUM_OUT=2 -> ch0 idx 0,1,2,3; ch1 idx 0,1,2,3 one cycle later; head saturates at 4.
//  5 Full slice drained, both r2b_slice_last seen -> single FLUSH cycle with b2r_rst_n=0, then IDLE; a second slice starts at wr_ptr=0.
//  6 rst_n low mid-RUN -> all outputs at reset values next edge; busy=0.

Source files
------------

// File: rtl/attn_softmax_sched_if.sv
// Handshake and strobe bundle between the attention softmax scheduler and the
// B2R converter, the softmax lane bank and the R2B output channels.
interface attn_softmax_sched_if #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_OUT  = 2,
  parameter int IDX_W    = $clog2(NUM_ROWS + NUM_OUT)
);
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic                     slice_done_b2r;
  logic                     b2r_rst_n;
  logic                     lane_en;
  logic [NUM_ROWS-1:0]      lane_valid;
  logic [NUM_ROWS-1:0]      lane_done;
  logic [NUM_ROWS-1:0]      lane_out_valid;
  logic [NUM_ROWS-1:0]      lane_rst_n;
  logic [NUM_OUT*IDX_W-1:0] r2b_row_idx;
  logic [NUM_OUT-1:0]       r2b_valid;
  logic [NUM_OUT-1:0]       r2b_slice_last;
  logic [NUM_OUT-1:0]       r2b_rst_n;
  logic                     busy;

  // Environment side: B2R source, lane bank and R2B channels.
  modport master (
    output in_valid, in_last, slice_done_b2r, lane_done, lane_out_valid, r2b_slice_last,
    input  in_ready, b2r_rst_n, lane_en, lane_valid, lane_rst_n, r2b_row_idx, r2b_valid,
           r2b_rst_n, busy
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_last, slice_done_b2r, lane_done, lane_out_valid, r2b_slice_last,
    output in_ready, b2r_rst_n, lane_en, lane_valid, lane_rst_n, r2b_row_idx, r2b_valid,
           r2b_rst_n, busy
  );
endinterface

// File: rtl/attn_softmax_sched.sv
// Slice scheduler for one self-attention head: round-robin tile dispatch into the
// softmax lanes, done-triggered local resets and diagonally skewed R2B mapping.
module attn_softmax_sched #(
  parameter int NUM_ROWS      = 4,
  parameter int TILES_PER_ROW = 2,
  parameter int NUM_OUT       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  attn_softmax_sched_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ROWS + NUM_OUT);
  localparam int PTR_W = $clog2(NUM_ROWS);
  localparam int CNT_W = $clog2(TILES_PER_ROW + 1);

  localparam logic [IDX_W-1:0] HEAD_MAX = IDX_W'(NUM_ROWS + NUM_OUT - 2);
  localparam logic [IDX_W-1:0] ROWS_IDX = IDX_W'(NUM_ROWS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TILES_PER_ROW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [CNT_W-1:0]         cnt_q [NUM_ROWS];
  logic [NUM_ROWS-1:0]      full;
  logic [NUM_ROWS-1:0]      lane_busy;
  logic [IDX_W-1:0]         head_q;
  logic [NUM_OUT-1:0]       seen_last_q;
  logic                     accept;

  logic                     lane_en_q;
  logic [NUM_ROWS-1:0]      lane_valid_q;
  logic [NUM_ROWS-1:0]      lane_rst_n_q;
  logic                     b2r_rst_q;
  logic [NUM_OUT*IDX_W-1:0] r2b_idx_q, r2b_idx_d;
  logic [NUM_OUT-1:0]       r2b_valid_q, r2b_valid_d;
  logic [NUM_OUT-1:0]       r2b_rst_n_q;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_occ
    assign full[r]      = (cnt_q[r] == CNT_FULL);
    assign lane_busy[r] = (cnt_q[r] != '0);
  end

  // A lane being reset this cycle cannot take a tile, and a full lane stalls the
  // stream rather than letting a later row overtake it.
  assign bus.in_ready = (state_q == RUN) && !full[wr_ptr_q] && !bus.lane_done[wr_ptr_q];
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every variable driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   if ((lane_busy == '0) && (&seen_last_q)) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous: rst_n is only looked at on the rising clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Channel m trails channel m-1 by one row, giving the diagonal skew into R2B.
  always_comb begin
    r2b_idx_d   = '0;
    r2b_valid_d = '0;
    for (int m = 0; m < NUM_OUT; m++) begin
      if ((head_q >= IDX_W'(m)) && ((head_q - IDX_W'(m)) < ROWS_IDX)) begin
        r2b_idx_d[m*IDX_W +: IDX_W] = head_q - IDX_W'(m);
        r2b_valid_d[m] = |(bus.lane_out_valid & (NUM_ROWS'(1) << (head_q - IDX_W'(m))));
      end
    end
  end

  // NOTE: non-blocking assignments make every register here see pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      head_q       <= '0;
      seen_last_q  <= '0;
      lane_en_q    <= 1'b0;
      lane_valid_q <= '0;
      lane_rst_n_q <= '0;
      b2r_rst_q    <= 1'b0;
      r2b_idx_q    <= '0;
      r2b_valid_q  <= '0;
      r2b_rst_n_q  <= '0;
      // NOTE: cnt_q is a flop array, not a RAM, so it can and must be cleared here.
      for (int r = 0; r < NUM_ROWS; r++) cnt_q[r] <= '0;
    end else begin
      lane_rst_n_q <= ~bus.lane_done;
      b2r_rst_q    <= ~bus.slice_done_b2r;
      r2b_rst_n_q  <= ~bus.r2b_slice_last;
      r2b_idx_q    <= r2b_idx_d;
      r2b_valid_q  <= r2b_valid_d;
      lane_valid_q <= accept ? (NUM_ROWS'(1) << wr_ptr_q) : '0;

      if ((state_q == IDLE) && bus.in_valid) lane_en_q <= 1'b1;

      for (int r = 0; r < NUM_ROWS; r++) begin
        if (bus.lane_done[r])                          cnt_q[r] <= '0;
        else if (accept && (wr_ptr_q == PTR_W'(r)))   cnt_q[r] <= cnt_q[r] + 1'b1;
      end

      if (state_q == FLUSH) begin
        wr_ptr_q    <= '0;
        head_q      <= '0;
        seen_last_q <= '0;
      end else begin
        if (accept) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if ((|bus.lane_out_valid) && (head_q != HEAD_MAX)) head_q <= head_q + 1'b1;
        seen_last_q <= seen_last_q | bus.r2b_slice_last;
      end
    end
  end

  assign bus.lane_en     = lane_en_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.lane_rst_n  = lane_rst_n_q;
  assign bus.b2r_rst_n   = b2r_rst_q && (state_q != FLUSH);
  assign bus.r2b_row_idx = r2b_idx_q;
  assign bus.r2b_valid   = r2b_valid_q;
  assign bus.r2b_rst_n   = r2b_rst_n_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_attn_softmax_sched.sv
// Self-checking bench for attn_softmax_sched: directed scenarios plus random traffic,
// all compared each cycle against a behavioural model of the scheduler.
module tb_attn_softmax_sched;
  localparam int NUM_ROWS = 4;
  localparam int TPR      = 2;
  localparam int NUM_OUT  = 2;
  localparam int IDX_W    = $clog2(NUM_ROWS + NUM_OUT);
  localparam int HEAD_MAX = NUM_ROWS + NUM_OUT - 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attn_softmax_sched_if #(.NUM_ROWS(NUM_ROWS), .NUM_OUT(NUM_OUT)) bus ();

  attn_softmax_sched #(
    .NUM_ROWS(NUM_ROWS), .TILES_PER_ROW(TPR), .NUM_OUT(NUM_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string               phase = "idle";
  bit                  model_ok = 1'b0;
  int                  m_ptr, m_head, row;
  int                  m_cnt [NUM_ROWS];
  bit [NUM_OUT-1:0]    m_seen;
  bit                  e_lane_en, e_b2r_q, acc, all_empty;
  bit [NUM_ROWS-1:0]   e_lane_valid, e_lane_rst_n;
  int                  e_idx [NUM_OUT];
  bit [NUM_OUT-1:0]    e_r2b_valid, e_r2b_rst_n;
  string               nxt;
  logic [NUM_OUT*IDX_W-1:0] e_idx_pk;

  function automatic bit model_in_ready();
    return (phase == "run") && (m_cnt[m_ptr] < TPR) && !bus.lane_done[m_ptr];
  endfunction

  task automatic model_reset();
    phase = "idle"; m_ptr = 0; m_head = 0; m_seen = '0;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    e_lane_en = 0; e_b2r_q = 0; e_lane_valid = '0; e_lane_rst_n = '0;
    e_r2b_valid = '0; e_r2b_rst_n = '0;
    foreach (e_idx[m]) e_idx[m] = 0;
    model_ok = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else if (model_ok) begin
      acc = bus.in_valid && model_in_ready();
      all_empty = 1;
      foreach (m_cnt[r]) if (m_cnt[r] != 0) all_empty = 0;
      if (phase == "idle")       nxt = bus.in_valid ? "run" : "idle";
      else if (phase == "run")   nxt = (acc && bus.in_last) ? "drain" : "run";
      else if (phase == "drain") nxt = (all_empty && (&m_seen)) ? "flush" : "drain";
      else                       nxt = "idle";

      if (phase == "idle" && bus.in_valid) e_lane_en = 1;
      e_lane_valid = '0;
      if (acc) e_lane_valid[m_ptr] = 1'b1;
      e_lane_rst_n = ~bus.lane_done;
      e_b2r_q      = !bus.slice_done_b2r;
      e_r2b_rst_n  = ~bus.r2b_slice_last;
      for (int m = 0; m < NUM_OUT; m++) begin
        row = m_head - m;
        if (row >= 0 && row < NUM_ROWS) begin
          e_idx[m] = row; e_r2b_valid[m] = bus.lane_out_valid[row];
        end else begin
          e_idx[m] = 0;   e_r2b_valid[m] = 1'b0;
        end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (bus.lane_done[r])         m_cnt[r] = 0;
        else if (acc && r == m_ptr)   m_cnt[r] = m_cnt[r] + 1;
      end
      if (phase == "flush") begin
        m_ptr = 0; m_head = 0; m_seen = '0;
      end else begin
        if (acc) m_ptr = (m_ptr + 1) % NUM_ROWS;
        if ((|bus.lane_out_valid) && m_head < HEAD_MAX) m_head = m_head + 1;
        m_seen = m_seen | bus.r2b_slice_last;
      end
      phase = nxt;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      for (int m = 0; m < NUM_OUT; m++) e_idx_pk[m*IDX_W +: IDX_W] = IDX_W'(e_idx[m]);
      check("in_ready",    bus.in_ready,    model_in_ready());
      check("busy",        bus.busy,        phase != "idle");
      check("b2r_rst_n",   bus.b2r_rst_n,   e_b2r_q && (phase != "flush"));
      check("lane_en",     bus.lane_en,     e_lane_en);
      check("lane_valid",  bus.lane_valid,  e_lane_valid);
      check("lane_rst_n",  bus.lane_rst_n,  e_lane_rst_n);
      check("r2b_row_idx", bus.r2b_row_idx, e_idx_pk);
      check("r2b_valid",   bus.r2b_valid,   e_r2b_valid);
      check("r2b_rst_n",   bus.r2b_rst_n,   e_r2b_rst_n);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 0; bus.in_last = 0; bus.slice_done_b2r = 0;
    bus.lane_done = '0; bus.lane_out_valid = '0; bus.r2b_slice_last = '0;
  endtask

  task automatic drain_all(input string tag);
    int  flush_cycles = 0;
    bit  idle_seen    = 0;
    bus.lane_done = '1; bus.r2b_slice_last = '1;
    tick();
    bus.lane_done = '0; bus.r2b_slice_last = '0;
    check({tag, "_lane_rst_pulse"}, bus.lane_rst_n, 0);
    check({tag, "_r2b_rst_pulse"},  bus.r2b_rst_n,  0);
    for (int k = 0; k < 20 && !idle_seen; k++) begin
      if (bus.busy && !bus.b2r_rst_n) flush_cycles++;
      if (!bus.busy) idle_seen = 1;
      else tick();
    end
    check({tag, "_reached_idle"}, idle_seen, 1);
    check({tag, "_flush_cycles"}, flush_cycles, 1);
  endtask

  int ch0_obs [4];
  int ch1_obs [4];
  int t1_exp  [8] = '{1, 2, 4, 8, 1, 2, 4, 8};

  initial begin
    logic [NUM_ROWS-1:0] rd;
    logic [NUM_OUT-1:0]  rl;
    clear_inputs();
    rst_n = 0;
    repeat (3) tick();
    check("rst_in_ready",   bus.in_ready,    0);
    check("rst_busy",       bus.busy,        0);
    check("rst_lane_rst_n", bus.lane_rst_n,  0);
    check("rst_b2r_rst_n",  bus.b2r_rst_n,   0);
    check("rst_r2b_rst_n",  bus.r2b_rst_n,   0);
    check("rst_r2b_idx",    bus.r2b_row_idx, 0);
    rst_n = 1;
    tick();
    check("post_rst_lane_rst_n", bus.lane_rst_n, 4'hF);
    check("post_rst_b2r_rst_n",  bus.b2r_rst_n,  1);

    // Output mapping: rows 0..3 one after another, then head saturation.
    for (int i = 0; i < 5; i++) begin
      bus.lane_out_valid = (i < 4) ? NUM_ROWS'(1 << i) : '0;
      tick();
      if (i < 4) ch0_obs[i]   = int'(bus.r2b_row_idx[IDX_W-1:0]);
      if (i > 0) ch1_obs[i-1] = int'(bus.r2b_row_idx[IDX_W +: IDX_W]);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_ch0_idx%0d", i), ch0_obs[i], i);
      check($sformatf("t4_ch1_idx%0d", i), ch1_obs[i], i);
    end
    check("t4_ch0_out_of_range", bus.r2b_valid[0], 0);
    bus.lane_out_valid = 4'b1000;
    tick();
    check("t4_sat_ch1_idx",   bus.r2b_row_idx[IDX_W +: IDX_W], 3);
    check("t4_sat_ch1_valid", bus.r2b_valid, 2'b10);
    bus.lane_out_valid = '0;
    tick();
    check("t4_sat_hold_idx", bus.r2b_row_idx[IDX_W +: IDX_W], 3);

    // Eight back-to-back tiles, last on the eighth.
    bus.in_valid = 1;
    tick();
    check("t1_lane_en", bus.lane_en, 1);
    for (int i = 0; i < 8; i++) begin
      bus.in_last = (i == 7);
      #1 check($sformatf("t1_in_ready%0d", i), bus.in_ready, 1);
      tick();
      check($sformatf("t1_lane_valid%0d", i), bus.lane_valid, t1_exp[i]);
    end
    bus.in_last = 0;
    #1 check("t1_drain_no_ready", bus.in_ready, 0);
    check("t1_model_drain", phase == "drain", 1);
    bus.in_valid = 0;
    drain_all("t5");

    // Second slice restarts at lane 0, fills every lane and stalls.
    bus.in_valid = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) check("t5_restart_lane0", bus.lane_valid, 1);
    end
    #1 check("t2_all_full", bus.in_ready, 0);
    tick();
    check("t2_stall_no_strobe", bus.lane_valid, 0);
    bus.lane_done = 4'b0001;
    #1 check("t2_done_cycle", bus.in_ready, 0);
    tick();
    bus.lane_done = '0;
    #1 check("t2_lane0_rst", bus.lane_rst_n, 4'b1110);
    check("t2_lane0_ready", bus.in_ready, 1);
    tick();
    check("t2_lane0_refill", bus.lane_valid, 1);
    #1 check("t2_lane1_full", bus.in_ready, 0);
    bus.lane_done = 4'b0110;
    tick();
    bus.lane_done = '0;
    #1 check("t2_lane1_ready", bus.in_ready, 1);
    tick();
    check("t2_lane1_refill", bus.lane_valid, 2);

    // lane_done and a tile for the same lane collide: done wins.
    bus.lane_done = 4'b0100;
    #1 check("t3_done_wins", bus.in_ready, 0);
    tick();
    bus.lane_done = '0;
    check("t3_no_strobe", bus.lane_valid, 0);
    check("t3_model_cnt2", m_cnt[2], 0);
    bus.in_last = 1;
    #1 check("t3_ready_after", bus.in_ready, 1);
    tick();
    check("t3_lane2_strobe", bus.lane_valid, 4);
    bus.in_last = 0; bus.in_valid = 0;
    drain_all("t3");

    // Random traffic, compared against the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid       = ($urandom_range(0, 9) < 7);
      bus.in_last        = ($urandom_range(0, 9) == 0);
      bus.slice_done_b2r = ($urandom_range(0, 9) == 0);
      bus.lane_out_valid = NUM_ROWS'($urandom);
      for (int r = 0; r < NUM_ROWS; r++) rd[r] = ($urandom_range(0, 9) == 0);
      for (int m = 0; m < NUM_OUT; m++)  rl[m] = ($urandom_range(0, 19) == 0);
      bus.lane_done      = rd;
      bus.r2b_slice_last = rl;
      tick();
    end

    // Reset in the middle of a running slice.
    clear_inputs();
    rst_n = 0; tick(); rst_n = 1; tick();
    bus.in_valid = 1; bus.lane_out_valid = 4'b0001;
    repeat (3) tick();
    check("t6_busy_before", bus.busy, 1);
    rst_n = 0;
    tick();
    check("t6_in_ready",   bus.in_ready,    0);
    check("t6_busy",       bus.busy,        0);
    check("t6_lane_en",    bus.lane_en,     0);
    check("t6_lane_valid", bus.lane_valid,  0);
    check("t6_r2b_valid",  bus.r2b_valid,   0);
    check("t6_r2b_idx",    bus.r2b_row_idx, 0);
    check("t6_b2r_rst_n",  bus.b2r_rst_n,   0);
    check("t6_lane_rst_n", bus.lane_rst_n,  0);
    check("t6_r2b_rst_n",  bus.r2b_rst_n,   0);
    clear_inputs();
    rst_n = 1;
    tick();
    check("t6_idle_after", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
